// File: rtl/puck_pkg.sv
// puck_pkg: constants and types shared by the uart receive path.
// The top level and the cpu size their rx wiring from these values.
//   BYTE_W              width of a received byte
//   RX_FIFO_DEPTH_LOG2  default log2 depth of the receive FIFO
//   ERR_CNT_W           width of the saturating framing-error counter
package puck_pkg;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned RX_FIFO_DEPTH_LOG2 = 4;
    localparam int unsigned ERR_CNT_W          = 8;

    typedef logic [BYTE_W-1:0]    byte_t;
    typedef logic [ERR_CNT_W-1:0] err_cnt_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bundle between the uart receiver/consumer side and the
// receive FIFO.
//   received, rx_byte, recv_error  strobe, byte and framing error from the uart
//   pop, clr_status                consumer controls
//   dout, valid, level             show-ahead read side and fill level
//   overflow, err_count, rts_n     status and host flow control
// Modports: master = receiver/consumer side, slave = FIFO.
interface uart_rx_fifo_if
    import puck_pkg::*;
#(
    parameter int unsigned depth_log2 = RX_FIFO_DEPTH_LOG2
) ();

    logic                received;
    byte_t               rx_byte;
    logic                recv_error;
    logic                pop;
    logic                clr_status;
    byte_t               dout;
    logic                valid;
    logic [depth_log2:0] level;
    logic                overflow;
    err_cnt_t            err_count;
    logic                rts_n;

    modport master (
        output received, rx_byte, recv_error, pop, clr_status,
        input  dout, valid, level, overflow, err_count, rts_n
    );

    modport slave (
        input  received, rx_byte, recv_error, pop, clr_status,
        output dout, valid, level, overflow, err_count, rts_n
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// rx_fifo_mem: 2**depth_log2 x width register array for the receive FIFO.
// One synchronous write port and one asynchronous read port, so the FIFO
// head is visible on rdata with no read latency. Contents are never reset.
//   clk    system clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
module rx_fifo_mem
    import puck_pkg::*;
#(
    parameter int unsigned depth_log2 = RX_FIFO_DEPTH_LOG2,
    parameter int unsigned width      = BYTE_W
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [depth_log2-1:0] waddr,
    input  logic [width-1:0]      wdata,
    input  logic [depth_log2-1:0] raddr,
    output logic [width-1:0]      rdata
);

    logic [width-1:0] mem [2**depth_log2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the uart receiver and its consumers.
// Every error-free received strobe is captured into a FIFO; consumers see a
// show-ahead interface (dout valid whenever valid=1, removed by a 1-cycle pop).
//   clk   system clock, single domain
//   rst   synchronous reset, active high
//   rx    uart_rx_fifo_if.slave: received/rx_byte/recv_error in,
//         pop/clr_status in, dout/valid/level/overflow/err_count/rts_n out
// Build option: define RX_RTS_EN for hysteretic RTS flow control driven by
// high_water/low_water; otherwise rts_n is tied to 0.
module uart_rx_fifo
    import puck_pkg::*;
#(
    parameter int unsigned depth_log2 = RX_FIFO_DEPTH_LOG2,
    parameter int unsigned high_water = 12,
    parameter int unsigned low_water  = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  rx
);

    // Reject illegal configurations at elaboration.
    if (depth_log2 < 2 || depth_log2 > 8) begin : g_bad_depth
        $error("uart_rx_fifo: depth_log2 must be 2..8");
    end
    if (high_water >= 2**depth_log2 || low_water >= high_water) begin : g_bad_water
        $error("uart_rx_fifo: need low_water < high_water < 2**depth_log2");
    end

    // Level of a completely full FIFO, i.e. 2**depth_log2 in depth_log2+1 bits.
    localparam logic [depth_log2:0] FULL_LEVEL = {1'b1, {depth_log2{1'b0}}};

    logic [depth_log2-1:0] wr_ptr;
    logic [depth_log2-1:0] rd_ptr;
    logic [depth_log2:0]   level_q;
    logic [depth_log2:0]   level_next;
    logic                  valid_q;
    logic                  overflow_q;
    err_cnt_t              err_count_q;

    logic full;
    logic pop_ok;
    logic push_req;
    logic push_ok;
    logic drop;
    logic err_hit;

    always_comb begin
        full     = (level_q == FULL_LEVEL);
        pop_ok   = rx.pop && valid_q;
        push_req = rx.received && !rx.recv_error;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok  = push_req && (!full || pop_ok);
        drop     = push_req && full && !pop_ok;
        err_hit  = rx.received && rx.recv_error;

        level_next = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level_q + 1'b1;
            2'b01:   level_next = level_q - 1'b1;
            default: level_next = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q <= level_next;
            valid_q <= (level_next != '0);

            // Clear wins over a same-cycle set.
            if (rx.clr_status) begin
                overflow_q  <= 1'b0;
                err_count_q <= '0;
            end else begin
                if (drop) begin
                    overflow_q <= 1'b1;
                end
                if (err_hit && err_count_q != '1) begin
                    err_count_q <= err_count_q + 1'b1;
                end
            end
        end
    end

    rx_fifo_mem #(
        .depth_log2 (depth_log2),
        .width      (BYTE_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok && !rst),
        .waddr (wr_ptr),
        .wdata (rx.rx_byte),
        .raddr (rd_ptr),
        .rdata (rx.dout)
    );

    assign rx.valid     = valid_q;
    assign rx.level     = level_q;
    assign rx.overflow  = overflow_q;
    assign rx.err_count = err_count_q;

`ifdef RX_RTS_EN
    localparam logic [depth_log2:0] HIGH_LEVEL = high_water[depth_log2:0];
    localparam logic [depth_log2:0] LOW_LEVEL  = low_water[depth_log2:0];

    logic rts_q;

    // Hysteresis on the post-update level: between the marks rts_n holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            rts_q <= 1'b0;
        end else if (level_next >= HIGH_LEVEL) begin
            rts_q <= 1'b1;
        end else if (level_next <= LOW_LEVEL) begin
            rts_q <= 1'b0;
        end
    end

    assign rx.rts_n = rts_q;
`else
    assign rx.rts_n = 1'b0;
`endif

endmodule
